npc_predict: RTL

Parametrised next-PC unit for the multi-cycle/pipelined CPU. It owns the fetch PC register and predicts the next PC with a direct-mapped branch target buffer (BTB) of 2-bit saturating counters. It resolves the real next PC from execute-stage results using the classic branch, jump, jump-register and sequential rules, and redirects fetch when the prediction was wrong. It sits between the fetch stage, which consumes `pc`, and the control/ALU path, which supplies the `ex_*` inputs.

---
 rtl/npc_predict.sv | 127 ++++++++++++
 1 files changed

// File: rtl/npc_predict.sv
// rtl/npc_predict.sv - fetch PC register with BTB-based next-PC prediction and execute-stage redirect
module npc_predict #(
    parameter int                XLEN        = 32,
    parameter logic [XLEN-1:0]   RESET_PC    = '0,
    parameter int                BTB_ENTRIES = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pred_npc,
    output logic            pred_taken,
    input  logic            ex_valid,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [1:0]      ex_kind,
    input  logic            ex_zero,
    input  logic [XLEN-1:0] ex_offset,
    input  logic [25:0]     ex_instr_index,
    input  logic [XLEN-1:0] ex_reg,
    input  logic [XLEN-1:0] ex_pred_npc,
    output logic            flush
);

    localparam int IW = $clog2(BTB_ENTRIES);
    localparam int TW = XLEN - IW - 2;
    localparam logic [XLEN-1:0] FOUR = XLEN'(4);

    localparam logic [1:0] K_BRANCH = 2'b00;
    localparam logic [1:0] K_JUMP   = 2'b01;
    localparam logic [1:0] K_JREG   = 2'b10;

    logic            btb_valid  [BTB_ENTRIES];
    logic [TW-1:0]   btb_tag    [BTB_ENTRIES];
    logic [XLEN-1:0] btb_target [BTB_ENTRIES];
    logic [1:0]      btb_ctr    [BTB_ENTRIES];

    logic [IW-1:0]   fetch_idx;
    logic [TW-1:0]   fetch_tag;
    logic            fetch_hit;

    logic [IW-1:0]   ex_idx;
    logic [TW-1:0]   ex_tag;
    logic            ex_hit;

    logic [XLEN-1:0] seq;
    logic [XLEN-1:0] branch_target;
    logic [XLEN-1:0] act_npc;
    logic            act_taken;

    assign fetch_idx  = pc[IW+1:2];
    assign fetch_tag  = pc[XLEN-1:IW+2];
    assign fetch_hit  = btb_valid[fetch_idx] && (btb_tag[fetch_idx] == fetch_tag);
    assign pred_taken = fetch_hit && btb_ctr[fetch_idx][1];
    assign pred_npc   = pred_taken ? btb_target[fetch_idx] : pc + FOUR;

    assign ex_idx = ex_pc[IW+1:2];
    assign ex_tag = ex_pc[XLEN-1:IW+2];
    assign ex_hit = btb_valid[ex_idx] && (btb_tag[ex_idx] == ex_tag);

    assign seq           = ex_pc + FOUR;
    assign branch_target = seq + (ex_offset << 2);

    always_comb begin
        act_npc   = seq;
        act_taken = 1'b0;
        case (ex_kind)
            K_BRANCH: begin
                act_npc   = ex_zero ? branch_target : seq;
                act_taken = ex_zero;
            end
            K_JUMP: begin
                act_npc   = {seq[XLEN-1:28], ex_instr_index, 2'b00};
                act_taken = 1'b1;
            end
            K_JREG: begin
                act_npc   = ex_reg;
                act_taken = 1'b1;
            end
            default: begin
                act_npc   = seq;
                act_taken = 1'b0;
            end
        endcase
    end

    assign flush = ex_valid && (act_npc != ex_pred_npc);

    // Fetch lookup reads the arrays combinationally, so a same-cycle write is seen only next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                btb_valid[i]  <= 1'b0;
                btb_tag[i]    <= '0;
                btb_target[i] <= '0;
                btb_ctr[i]    <= 2'b01;
            end
        end else begin
            if (flush) begin
                pc <= act_npc;
            end else if (!stall) begin
                pc <= pred_npc;
            end

            if (ex_valid) begin
                if (act_taken) begin
                    if (ex_hit) begin
                        btb_target[ex_idx] <= act_npc;
                        if (btb_ctr[ex_idx] != 2'b11) begin
                            btb_ctr[ex_idx] <= btb_ctr[ex_idx] + 2'd1;
                        end
                    end else begin
                        btb_valid[ex_idx]  <= 1'b1;
                        btb_tag[ex_idx]    <= ex_tag;
                        btb_target[ex_idx] <= act_npc;
                        btb_ctr[ex_idx]    <= (ex_kind == K_BRANCH) ? 2'b10 : 2'b11;
                    end
                end else if (ex_kind == K_BRANCH && ex_hit) begin
                    if (btb_ctr[ex_idx] != 2'b00) begin
                        btb_ctr[ex_idx] <= btb_ctr[ex_idx] - 2'd1;
                    end
                end
            end
        end
    end

endmodule
